// File: rtl/br_game_fsm.sv
// -----------------------------------------------------------------------------
// br_game_fsm
// Game-status sequencer for BlockyRoads. Drives the 2-bit status bus
// (00 load, 01 activate, 10 pause, 11 terminate) used by the renderer and
// the model. It also keeps the BCD score and the speed level.
//
// Ports
//   clk        in   1   system clock
//   clr        in   1   asynchronous reset, active-low
//   frame_tick in   1   one-cycle pulse per video frame
//   key_start  in   1   one-cycle pulse, START key decoded
//   key_pause  in   1   one-cycle pulse, PAUSE key decoded
//   collide    in   1   level, car overlaps an obstacle
//   status     out  2   current game status
//   scroll_en  out  1   high while status == activate
//   game_rst   out  1   one-cycle pulse on each new game (entry from load/terminate)
//   score      out  16  4 BCD digits, [15:12] thousands .. [3:0] units
//   speed      out  3   difficulty level 0..MAX_SPEED
// -----------------------------------------------------------------------------
module br_game_fsm #(
  parameter int LOAD_FRAMES      = 120,
  parameter int TERM_LOCK_FRAMES = 60,
  parameter int SCORE_DIV        = 6,
  parameter int MAX_SPEED        = 7
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        frame_tick,
  input  logic        key_start,
  input  logic        key_pause,
  input  logic        collide,
  output logic [1:0]  status,
  output logic        scroll_en,
  output logic        game_rst,
  output logic [15:0] score,
  output logic [2:0]  speed
);

  localparam int FCNT_MAX = (LOAD_FRAMES > TERM_LOCK_FRAMES) ? LOAD_FRAMES : TERM_LOCK_FRAMES;
  localparam int FCNT_W   = $clog2(FCNT_MAX + 1);
  // A divide-by-1 still needs a 1-bit register to stay legal.
  localparam int DIV_W    = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;

  localparam logic [FCNT_W-1:0] LOAD_THR  = FCNT_W'(LOAD_FRAMES);
  localparam logic [FCNT_W-1:0] TERM_THR  = FCNT_W'(TERM_LOCK_FRAMES);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCORE_DIV - 1);
  localparam logic [2:0]        SPEED_TOP = 3'(MAX_SPEED);
  localparam logic [15:0]       SCORE_TOP = 16'h9999;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_PAUSE  = 2'b10,
    ST_TERM   = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [15:0]         score_q, score_d;
  logic [2:0]          speed_q, speed_d;
  logic                scroll_q, scroll_d;
  logic                grst_q, grst_d;
  logic                new_game;

  // BCD +1 with ripple carry across the four digits. The caller never
  // passes 9999, so the final carry-out is not needed.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    div_d    = div_q;
    score_d  = score_q;
    speed_d  = speed_q;
    grst_d   = 1'b0;
    new_game = 1'b0;

    case (state_q)
      ST_LOAD:   if (key_start && fcnt_q == LOAD_THR) state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        // A collision outranks a pause request in the same cycle.
        if (collide)        state_d = ST_TERM;
        else if (key_pause) state_d = ST_PAUSE;
      end
      ST_PAUSE:  if (key_pause) state_d = ST_ACTIVE;
      ST_TERM:   if (key_start && fcnt_q == TERM_THR) state_d = ST_ACTIVE;
      default:   state_d = ST_LOAD;
    endcase

    // Frame counter restarts on any state change and only counts in the
    // two lock-out states, parking at that state's threshold.
    if (state_d != state_q) begin
      fcnt_d = '0;
    end else if (frame_tick && state_q == ST_LOAD && fcnt_q != LOAD_THR) begin
      fcnt_d = fcnt_q + FCNT_W'(1);
    end else if (frame_tick && state_q == ST_TERM && fcnt_q != TERM_THR) begin
      fcnt_d = fcnt_q + FCNT_W'(1);
    end

    // Scoring looks at the pre-edge state, so a tick arriving together
    // with the collision still counts.
    if (state_q == ST_ACTIVE && frame_tick) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        if (score_q != SCORE_TOP) begin
          score_d = bcd_inc(score_q);
          // Tens+units rolling 99 -> 00 bumps the difficulty.
          if (score_q[7:0] == 8'h99 && speed_q != SPEED_TOP) begin
            speed_d = speed_q + 3'd1;
          end
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end

    // Starting a fresh game (not a resume from pause) wipes the game state.
    if (state_d == ST_ACTIVE && (state_q == ST_LOAD || state_q == ST_TERM)) begin
      new_game = 1'b1;
    end
    if (new_game) begin
      grst_d  = 1'b1;
      score_d = '0;
      speed_d = '0;
      div_d   = '0;
    end

    scroll_d = (state_d == ST_ACTIVE);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= ST_LOAD;
      fcnt_q   <= '0;
      div_q    <= '0;
      score_q  <= '0;
      speed_q  <= '0;
      scroll_q <= 1'b0;
      grst_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      div_q    <= div_d;
      score_q  <= score_d;
      speed_q  <= speed_d;
      scroll_q <= scroll_d;
      grst_q   <= grst_d;
    end
  end

  assign status    = state_q;
  assign scroll_en = scroll_q;
  assign game_rst  = grst_q;
  assign score     = score_q;
  assign speed     = speed_q;

endmodule

// File: tb/tb_br_game_fsm.sv
// -----------------------------------------------------------------------------
// tb_br_game_fsm
// Self-checking bench for br_game_fsm: a table of single-cycle vectors,
// hand-written multi-cycle scenarios and a randomized phase. All of them are
// checked against an integer reference model of the game rules.
// -----------------------------------------------------------------------------
module tb_br_game_fsm;

  localparam int LOAD_FRAMES      = 120;
  localparam int TERM_LOCK_FRAMES = 60;
  localparam int SCORE_DIV        = 6;
  localparam int MAX_SPEED        = 7;

  logic        clk;
  logic        clr;
  logic        frame_tick;
  logic        key_start;
  logic        key_pause;
  logic        collide;
  logic [1:0]  status;
  logic        scroll_en;
  logic        game_rst;
  logic [15:0] score;
  logic [2:0]  speed;

  int n_cmp;
  int n_err;

  // Reference model: 0 load, 1 activate, 2 pause, 3 terminate.
  int m_state;
  int m_fcnt;
  int m_div;
  int m_score;
  int m_speed;
  bit m_grst;

  br_game_fsm #(
    .LOAD_FRAMES     (LOAD_FRAMES),
    .TERM_LOCK_FRAMES(TERM_LOCK_FRAMES),
    .SCORE_DIV       (SCORE_DIV),
    .MAX_SPEED       (MAX_SPEED)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .frame_tick(frame_tick),
    .key_start (key_start),
    .key_pause (key_pause),
    .collide   (collide),
    .status    (status),
    .scroll_en (scroll_en),
    .game_rst  (game_rst),
    .score     (score),
    .speed     (speed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         t;
    bit         s;
    bit         p;
    bit         c;
    logic [1:0] st;
    bit         scr;
    bit         grst;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_fcnt  = 0;
    m_div   = 0;
    m_score = 0;
    m_speed = 0;
    m_grst  = 0;
  endtask

  task automatic model_step(input bit t, input bit s, input bit p, input bit c);
    int ns;
    ns = m_state;
    case (m_state)
      0: if (s && m_fcnt == LOAD_FRAMES) ns = 1;
      1: if (c) ns = 3; else if (p) ns = 2;
      2: if (p) ns = 1;
      default: if (s && m_fcnt == TERM_LOCK_FRAMES) ns = 1;
    endcase
    if (m_state == 1 && t) begin
      m_div = m_div + 1;
      if (m_div == SCORE_DIV) begin
        m_div = 0;
        if (m_score < 9999) begin
          m_score = m_score + 1;
          if (m_score % 100 == 0 && m_speed < MAX_SPEED) m_speed = m_speed + 1;
        end
      end
    end
    if (ns != m_state) m_fcnt = 0;
    else if (t && m_state == 0 && m_fcnt < LOAD_FRAMES) m_fcnt = m_fcnt + 1;
    else if (t && m_state == 3 && m_fcnt < TERM_LOCK_FRAMES) m_fcnt = m_fcnt + 1;
    m_grst = (ns == 1) && (m_state == 0 || m_state == 3);
    if (m_grst) begin
      m_score = 0;
      m_speed = 0;
      m_div   = 0;
    end
    m_state = ns;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".status"},    16'(status),    16'(m_state));
    check({tag, ".scroll_en"}, 16'(scroll_en), 16'(m_state == 1));
    check({tag, ".game_rst"},  16'(game_rst),  16'(m_grst));
    check({tag, ".score"},     score,          to_bcd(m_score));
    check({tag, ".speed"},     16'(speed),     16'(m_speed));
  endtask

  // One clock cycle of stimulus; called and returning at a falling edge.
  task automatic step(input bit t, input bit s, input bit p, input bit c, input bit chk);
    frame_tick = t;
    key_start  = s;
    key_pause  = p;
    collide    = c;
    @(posedge clk);
    model_step(t, s, p, c);
    @(negedge clk);
    frame_tick = 1'b0;
    key_start  = 1'b0;
    key_pause  = 1'b0;
    collide    = 1'b0;
    if (chk) check_model("model");
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    clr        = 1'b0;
    frame_tick = 1'b0;
    key_start  = 1'b0;
    key_pause  = 1'b0;
    collide    = 1'b0;
    model_reset();

    // From a fresh game: pause/resume/crash behaviour of single cycles.
    vecs[0] = '{t: 0, s: 0, p: 1, c: 0, st: 2'b10, scr: 0, grst: 0};
    vecs[1] = '{t: 0, s: 1, p: 0, c: 0, st: 2'b10, scr: 0, grst: 0};
    vecs[2] = '{t: 1, s: 0, p: 0, c: 1, st: 2'b10, scr: 0, grst: 0};
    vecs[3] = '{t: 0, s: 0, p: 1, c: 0, st: 2'b01, scr: 1, grst: 0};
    vecs[4] = '{t: 0, s: 1, p: 0, c: 0, st: 2'b01, scr: 1, grst: 0};
    vecs[5] = '{t: 0, s: 0, p: 1, c: 1, st: 2'b11, scr: 0, grst: 0};
    vecs[6] = '{t: 0, s: 1, p: 1, c: 0, st: 2'b11, scr: 0, grst: 0};

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst.status", 16'(status), 16'd0);
    check("rst.scroll", 16'(scroll_en), 16'd0);
    check("rst.grst", 16'(game_rst), 16'd0);
    check("rst.score", score, 16'h0000);
    check("rst.speed", 16'(speed), 16'd0);
    clr = 1'b1;
    @(negedge clk);

    // Splash lock-out: START only counts once 120 ticks have been seen.
    ticks(119);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("load.early_start", 16'(status), 16'd0);
    ticks(1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("load.start.status", 16'(status), 16'd1);
    check("load.start.grst", 16'(game_rst), 16'd1);
    check("load.start.scroll", 16'(scroll_en), 16'd1);
    check("load.start.score", score, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("load.grst_1cyc", 16'(game_rst), 16'd0);

    // Table-driven single cycles
    for (int i = 0; i < 7; i++) begin
      step(vecs[i].t, vecs[i].s, vecs[i].p, vecs[i].c, 1'b1);
      check($sformatf("vec%0d.status", i), 16'(status), 16'(vecs[i].st));
      check($sformatf("vec%0d.scroll", i), 16'(scroll_en), 16'(vecs[i].scr));
      check($sformatf("vec%0d.grst", i), 16'(game_rst), 16'(vecs[i].grst));
    end

    // Leave terminate after the 60-tick lock-out.
    ticks(60);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("term.restart.status", 16'(status), 16'd1);
    check("term.restart.grst", 16'(game_rst), 16'd1);

    // Score rate: 6 ticks per point.
    ticks(60);
    check("play.score10", score, 16'h0010);
    check("play.speed0", 16'(speed), 16'd0);
    ticks(540);
    check("play.score100", score, 16'h0100);
    check("play.speed1", 16'(speed), 16'd1);

    // Pause freezes score and divider; resume picks up where it left off.
    ticks(3);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("pause.status", 16'(status), 16'd2);
    ticks(30);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("pause.hold.status", 16'(status), 16'd2);
    check("pause.hold.score", score, 16'h0100);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("resume.status", 16'(status), 16'd1);
    check("resume.no_grst", 16'(game_rst), 16'd0);
    ticks(2);
    check("resume.div_held", score, 16'h0100);
    ticks(1);
    check("resume.div_wrap", score, 16'h0101);

    // Collision beats pause; terminate lock-out boundary.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("crash.status", 16'(status), 16'd3);
    ticks(59);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("crash.early_start", 16'(status), 16'd3);
    check("crash.score_held", score, 16'h0101);
    ticks(1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("crash.restart.status", 16'(status), 16'd1);
    check("crash.restart.grst", 16'(game_rst), 16'd1);
    check("crash.restart.score", score, 16'h0000);

    // Long run to score saturation (checked every 1000 cycles).
    for (int i = 0; i < 59994; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, (i % 1000) == 999);
    end
    check("sat.score", score, 16'h9999);
    check("sat.speed", 16'(speed), 16'd7);
    ticks(12);
    check("sat.score_hold", score, 16'h9999);
    check("sat.speed_hold", 16'(speed), 16'd7);

    // Asynchronous clear mid-game, observed before the next rising edge.
    ticks(4);
    #2;
    clr = 1'b0;
    #1;
    check("clr.status", 16'(status), 16'd0);
    check("clr.score", score, 16'h0000);
    check("clr.scroll", 16'(scroll_en), 16'd0);
    check("clr.speed", 16'(speed), 16'd0);
    model_reset();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);

    // Randomized play checked cycle by cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 1) == 1), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
